// File: rtl/sregfile_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// sregfile_wb_arbiter_if : producer handshakes and register-file write port
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface sregfile_wb_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  alu_valid_i;
  logic                  alu_ready_o;
  logic [4:0]            alu_rd_i;
  logic [DATA_WIDTH-1:0] alu_data_i;
  logic                  lsu_valid_i;
  logic                  lsu_ready_o;
  logic [4:0]            lsu_rd_i;
  logic [DATA_WIDTH-1:0] lsu_data_i;
  logic                  vec_valid_i;
  logic                  vec_ready_o;
  logic [4:0]            vec_rd_i;
  logic [DATA_WIDTH-1:0] vec_data_i;
  logic                  reg_write_o;
  logic [4:0]            rd_addr_o;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic [31:0]           pending_o;
  logic                  idle_o;

  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i,
    output lsu_valid_i, lsu_rd_i, lsu_data_i,
    output vec_valid_i, vec_rd_i, vec_data_i,
    input  alu_ready_o, lsu_ready_o, vec_ready_o,
    input  reg_write_o, rd_addr_o, rd_data_o, pending_o, idle_o
  );

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i,
    input  lsu_valid_i, lsu_rd_i, lsu_data_i,
    input  vec_valid_i, vec_rd_i, vec_data_i,
    output alu_ready_o, lsu_ready_o, vec_ready_o,
    output reg_write_o, rd_addr_o, rd_data_o, pending_o, idle_o
  );
endinterface

`default_nettype wire

// File: rtl/sregfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// sregfile_wb_arbiter : buffers ALU/LSU/VEC writebacks, round-robin onto one port
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sregfile_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  sregfile_wb_arbiter_if.slave bus
);
  localparam int         NSRC     = 3;
  localparam int         PTR_W    = $clog2(FIFO_DEPTH);
  localparam int         CNT_W    = PTR_W + 1;
  localparam logic [1:0] SRC_LAST = 2'd2;

  logic [NSRC-1:0]       in_valid;
  logic [NSRC-1:0]       ready;
  logic [NSRC-1:0]       push;
  logic [NSRC-1:0]       pop;
  logic [4:0]            in_rd    [NSRC];
  logic [DATA_WIDTH-1:0] in_data  [NSRC];
  logic [4:0]            rd_mem   [NSRC][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [NSRC][FIFO_DEPTH];
  logic [PTR_W-1:0]      wptr     [NSRC];
  logic [PTR_W-1:0]      rptr     [NSRC];
  logic [CNT_W-1:0]      count    [NSRC];
  logic [4:0]            head_rd  [NSRC];
  logic [DATA_WIDTH-1:0] head_data[NSRC];

  logic [1:0]            last_grant;
  logic [1:0]            start;
  logic [2:0]            sum;
  logic [1:0]            cand;
  logic                  grant_valid;
  logic [1:0]            grant_idx;
  logic                  reg_write;
  logic [4:0]            rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [PTR_W-1:0]      off;
  logic [31:0]           pending;

  assign in_valid   = {bus.vec_valid_i, bus.lsu_valid_i, bus.alu_valid_i};
  assign in_rd[0]   = bus.alu_rd_i;
  assign in_rd[1]   = bus.lsu_rd_i;
  assign in_rd[2]   = bus.vec_rd_i;
  assign in_data[0] = bus.alu_data_i;
  assign in_data[1] = bus.lsu_data_i;
  assign in_data[2] = bus.vec_data_i;

  // x0 writes complete the handshake but are never enqueued
  generate
    for (genvar s = 0; s < NSRC; s++) begin : g_src
      assign ready[s]     = count[s] < CNT_W'(FIFO_DEPTH);
      assign push[s]      = in_valid[s] && ready[s] && (in_rd[s] != 5'd0);
      assign pop[s]       = grant_valid && (grant_idx == 2'(s));
      assign head_rd[s]   = rd_mem[s][rptr[s]];
      assign head_data[s] = data_mem[s][rptr[s]];
    end
  endgenerate

  assign start = (last_grant == SRC_LAST) ? 2'd0 : last_grant + 2'd1;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    sum         = 3'd0;
    cand        = 2'd0;
    for (int k = 0; k < NSRC; k++) begin
      sum = {1'b0, start} + 3'(k);
      if (sum >= 3'd3) sum = sum - 3'd3;
      cand = sum[1:0];
      if (!grant_valid && (count[cand] != '0)) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NSRC; s++) begin
        wptr[s]  <= '0;
        rptr[s]  <= '0;
        count[s] <= '0;
      end
      last_grant <= SRC_LAST;
      reg_write  <= 1'b0;
      rd_addr    <= 5'd0;
      rd_data    <= '0;
    end else begin
      for (int s = 0; s < NSRC; s++) begin
        if (push[s]) wptr[s] <= wptr[s] + PTR_W'(1);
        if (pop[s])  rptr[s] <= rptr[s] + PTR_W'(1);
        case ({push[s], pop[s]})
          2'b10:   count[s] <= count[s] + CNT_W'(1);
          2'b01:   count[s] <= count[s] - CNT_W'(1);
          default: count[s] <= count[s];
        endcase
      end
      reg_write <= grant_valid;
      if (grant_valid) begin
        last_grant <= grant_idx;
        rd_addr    <= head_rd[grant_idx];
        rd_data    <= head_data[grant_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < NSRC; s++) begin
      if (push[s]) begin
        rd_mem[s][wptr[s]]   <= in_rd[s];
        data_mem[s][wptr[s]] <= in_data[s];
      end
    end
  end

  // An entry is live when its distance from the read pointer is below the count
  always_comb begin
    pending = '0;
    off     = '0;
    for (int s = 0; s < NSRC; s++) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        off = PTR_W'(i) - rptr[s];
        if ({1'b0, off} < count[s]) pending[rd_mem[s][i]] = 1'b1;
      end
    end
    if (reg_write) pending[rd_addr] = 1'b1;
    pending[0] = 1'b0;
  end

  assign bus.alu_ready_o = ready[0];
  assign bus.lsu_ready_o = ready[1];
  assign bus.vec_ready_o = ready[2];
  assign bus.reg_write_o = reg_write;
  assign bus.rd_addr_o   = rd_addr;
  assign bus.rd_data_o   = rd_data;
  assign bus.pending_o   = pending;
  assign bus.idle_o      = (count[0] == '0) && (count[1] == '0) && (count[2] == '0) && !reg_write;

endmodule

`default_nettype wire

// File: tb/tb_sregfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sregfile_wb_arbiter : scoreboard bench for the scalar writeback arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sregfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sregfile_wb_arbiter_if #(.DATA_WIDTH(32)) bus();

  sregfile_wb_arbiter #(.DATA_WIDTH(32), .FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [36:0] q_alu[$];
  logic [36:0] q_lsu[$];
  logic [36:0] q_vec[$];
  logic [4:0]  wr_log[$];
  int          acc[3];

  // Accepted transfers become expected writes, one queue per source
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.alu_valid_i && bus.alu_ready_o) begin
        acc[0]++;
        if (bus.alu_rd_i != 5'd0) q_alu.push_back({bus.alu_rd_i, bus.alu_data_i});
      end
      if (bus.lsu_valid_i && bus.lsu_ready_o) begin
        acc[1]++;
        if (bus.lsu_rd_i != 5'd0) q_lsu.push_back({bus.lsu_rd_i, bus.lsu_data_i});
      end
      if (bus.vec_valid_i && bus.vec_ready_o) begin
        acc[2]++;
        if (bus.vec_rd_i != 5'd0) q_vec.push_back({bus.vec_rd_i, bus.vec_data_i});
      end
    end
  end

  always @(negedge clk) begin : mon
    logic [36:0] got;
    if (!rst && bus.reg_write_o) begin
      got = {bus.rd_addr_o, bus.rd_data_o};
      total++;
      wr_log.push_back(bus.rd_addr_o);
      if (q_alu.size() > 0 && q_alu[0] == got) void'(q_alu.pop_front());
      else if (q_lsu.size() > 0 && q_lsu[0] == got) void'(q_lsu.pop_front());
      else if (q_vec.size() > 0 && q_vec[0] == got) void'(q_vec.pop_front());
      else begin
        bad++;
        $display("FAIL scoreboard: write rd=%0d data=%h, required a source queue head", bus.rd_addr_o, bus.rd_data_o);
      end
    end
  end

  task automatic drive(input int src, input logic v, input logic [4:0] rd, input logic [31:0] d);
    case (src)
      0: begin bus.alu_valid_i = v; bus.alu_rd_i = rd; bus.alu_data_i = d; end
      1: begin bus.lsu_valid_i = v; bus.lsu_rd_i = rd; bus.lsu_data_i = d; end
      default: begin bus.vec_valid_i = v; bus.vec_rd_i = rd; bus.vec_data_i = d; end
    endcase
  endtask

  function automatic logic rdy(input int src);
    case (src)
      0: return bus.alu_ready_o;
      1: return bus.lsu_ready_o;
      default: return bus.vec_ready_o;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 5'd0, 32'd0);
    repeat (2) @(negedge clk);
    q_alu.delete(); q_lsu.delete(); q_vec.delete(); wr_log.delete();
    acc = '{0, 0, 0};
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic produce(input int src, input int n, input logic [4:0] rd0,
                         output bit saw_stall, output bit timed_out);
    int budget;
    saw_stall = 1'b0;
    timed_out = 1'b0;
    for (int i = 0; i < n; i++) begin
      drive(src, 1'b1, 5'(rd0 + 5'(i)), 32'hB000_0000 | (src << 8) | i);
      budget = 0;
      while (!rdy(src) && budget < 20) begin
        saw_stall = 1'b1;
        @(negedge clk);
        budget++;
      end
      if (!rdy(src)) timed_out = 1'b1;
      @(negedge clk);
    end
    drive(src, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.reg_write_o !== 1'b0) begin bad++; $display("FAIL rst_wr: got %b want 0", bus.reg_write_o); end
    total++; if (bus.rd_addr_o !== 5'd0) begin bad++; $display("FAIL rst_addr: got %0d want 0", bus.rd_addr_o); end
    total++; if (bus.rd_data_o !== 32'd0) begin bad++; $display("FAIL rst_data: got %h want 0", bus.rd_data_o); end
    total++; if (bus.pending_o !== 32'd0) begin bad++; $display("FAIL rst_pending: got %h want 0", bus.pending_o); end
    total++; if (bus.idle_o !== 1'b1) begin bad++; $display("FAIL rst_idle: got %b want 1", bus.idle_o); end
    total++; if ({bus.vec_ready_o, bus.lsu_ready_o, bus.alu_ready_o} !== 3'b111) begin
      bad++; $display("FAIL rst_ready: got %b want 111", {bus.vec_ready_o, bus.lsu_ready_o, bus.alu_ready_o});
    end
    for (int k = 0; k < 3; k++) begin
      drive(1, 1'b1, 5'(20 + k), 32'hC000_0000 + k);
      @(negedge clk);
    end
    drive(1, 1'b0, 5'd0, 32'd0);
    total++; if (bus.pending_o !== 32'h0060_0000) begin bad++; $display("FAIL mid_pending: got %h want 00600000", bus.pending_o); end
    #1 rst = 1'b1;
    #1;
    total++; if (bus.reg_write_o !== 1'b0 || bus.pending_o !== 32'd0 || bus.idle_o !== 1'b1) begin
      bad++; $display("FAIL mid_rst: wr=%b pending=%h idle=%b want 0/0/1", bus.reg_write_o, bus.pending_o, bus.idle_o);
    end
    q_alu.delete(); q_lsu.delete(); q_vec.delete(); wr_log.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    total++; if (wr_log.size() !== 0) begin bad++; $display("FAIL post_rst_writes: got %0d want 0", wr_log.size()); end
  endtask

  task automatic test_single();
    do_reset();
    drive(0, 1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    drive(0, 1'b0, 5'd0, 32'd0);
    total++; if (bus.reg_write_o !== 1'b0) begin bad++; $display("FAIL single_early: wr got %b want 0", bus.reg_write_o); end
    total++; if (bus.pending_o !== 32'h20) begin bad++; $display("FAIL single_pend0: got %h want 00000020", bus.pending_o); end
    @(negedge clk);
    total++; if (bus.reg_write_o !== 1'b1 || bus.rd_addr_o !== 5'd5 || bus.rd_data_o !== 32'hDEADBEEF) begin
      bad++; $display("FAIL single_write: wr=%b rd=%0d data=%h want 1/5/deadbeef", bus.reg_write_o, bus.rd_addr_o, bus.rd_data_o);
    end
    total++; if (bus.pending_o !== 32'h20) begin bad++; $display("FAIL single_pend1: got %h want 00000020", bus.pending_o); end
    @(negedge clk);
    total++; if (bus.reg_write_o !== 1'b0 || bus.pending_o !== 32'd0 || bus.idle_o !== 1'b1) begin
      bad++; $display("FAIL single_after: wr=%b pending=%h idle=%b want 0/0/1", bus.reg_write_o, bus.pending_o, bus.idle_o);
    end
  endtask

  task automatic test_contention();
    logic [4:0] exp_rd[6];
    exp_rd = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < 3; s++) drive(s, 1'b1, 5'(1 + 3 * r + s), 32'h1000_0000 + 32'(3 * r + s));
      @(negedge clk);
    end
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 6; i++) begin
      total++; if (bus.reg_write_o !== 1'b1 || bus.rd_addr_o !== exp_rd[i]) begin
        bad++; $display("FAIL contention[%0d]: wr=%b rd=%0d want 1/%0d", i, bus.reg_write_o, bus.rd_addr_o, exp_rd[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    bit a_stall, a_to, l_stall, l_to;
    int budget;
    logic [4:0] exp_rd[9];
    exp_rd = '{5'd16, 5'd24, 5'd17, 5'd25, 5'd18, 5'd26, 5'd19, 5'd27, 5'd20};
    do_reset();
    fork
      produce(0, 5, 5'd16, a_stall, a_to);
      produce(1, 4, 5'd24, l_stall, l_to);
    join
    total++; if (a_to || l_to) begin bad++; $display("FAIL bp_timeout: alu=%b lsu=%b want 0/0", a_to, l_to); end
    total++; if (l_stall !== 1'b1) begin bad++; $display("FAIL bp_lsu_stall: got %b want 1", l_stall); end
    budget = 0;
    while (!bus.idle_o && budget < 30) begin @(negedge clk); budget++; end
    total++; if (bus.idle_o !== 1'b1) begin bad++; $display("FAIL bp_drain: idle got %b want 1", bus.idle_o); end
    total++; if (wr_log.size() !== 9) begin bad++; $display("FAIL bp_count: got %0d want 9", wr_log.size()); end
    for (int i = 0; i < 9 && i < wr_log.size(); i++) begin
      total++; if (wr_log[i] !== exp_rd[i]) begin
        bad++; $display("FAIL bp_order[%0d]: got rd %0d want %0d", i, wr_log[i], exp_rd[i]);
      end
    end
  endtask

  task automatic test_x0();
    do_reset();
    drive(2, 1'b1, 5'd0, 32'h12345678);
    total++; if (bus.vec_ready_o !== 1'b1) begin bad++; $display("FAIL x0_ready: got %b want 1", bus.vec_ready_o); end
    @(negedge clk);
    drive(2, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.reg_write_o !== 1'b0 || bus.pending_o !== 32'd0 || bus.idle_o !== 1'b1) begin
        bad++; $display("FAIL x0_quiet[%0d]: wr=%b pending=%h idle=%b want 0/0/1", i, bus.reg_write_o, bus.pending_o, bus.idle_o);
      end
      @(negedge clk);
    end
    total++; if (acc[2] !== 1) begin bad++; $display("FAIL x0_handshake: got %0d want 1", acc[2]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_p;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      if (k >= 1 && k <= 8) begin
        total++; if (bus.alu_ready_o !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d]: got %b want 1", k, bus.alu_ready_o); end
      end
      if (k >= 2) begin
        total++; if (bus.reg_write_o !== 1'b1 || bus.rd_addr_o !== 5'(7 + k - 2) || bus.rd_data_o !== 32'hA000_0000 + 32'(k - 2)) begin
          bad++; $display("FAIL stream_wr[%0d]: wr=%b rd=%0d data=%h want 1/%0d/%h", k, bus.reg_write_o, bus.rd_addr_o,
                          bus.rd_data_o, 7 + k - 2, 32'hA000_0000 + 32'(k - 2));
        end
      end
      if (k >= 2 && k <= 8) begin
        exp_p = (32'd1 << (7 + k - 1)) | (32'd1 << (7 + k - 2));
        total++; if (bus.pending_o !== exp_p) begin bad++; $display("FAIL stream_pend[%0d]: got %h want %h", k, bus.pending_o, exp_p); end
      end
      if (k < 8) drive(0, 1'b1, 5'(7 + k), 32'hA000_0000 + 32'(k));
      else       drive(0, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_x0();
    test_back_to_back();
    repeat (3) @(negedge clk);
    total++; if (q_alu.size() + q_lsu.size() + q_vec.size() !== 0) begin
      bad++; $display("FAIL leftover: got %0d queued writes want 0", q_alu.size() + q_lsu.size() + q_vec.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
